// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: row layout, index type and sizing constants.
package reorder_buffer_pkg;

    localparam int ROB_IDX_W = 4;
    localparam int ROB_DEPTH = 1 << ROB_IDX_W;
    localparam int PREG_W    = 7;

    typedef logic [ROB_IDX_W-1:0] rob_idx;
    typedef logic [PREG_W-1:0]    p_reg;

    typedef struct packed {
        logic valid;
        logic complete;
        p_reg PRegAddrDst;
        p_reg OldPRegAddrDst;
        logic RegWrite;
    } rob_row_struct;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates rows at dispatch, marks them complete
// out of order, and retires from the head one row per cycle.
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int ROB_IDX_W = 4,
    parameter int PREG_W    = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dispatch_valid,
    input  logic [PREG_W-1:0]    dispatch_PRegAddrDst,
    input  logic [PREG_W-1:0]    dispatch_OldPRegAddrDst,
    input  logic                 dispatch_RegWrite,
    output logic                 dispatch_ready,
    output logic [ROB_IDX_W-1:0] dispatch_ROBNumber,
    input  logic                 complete_ready,
    input  logic [ROB_IDX_W-1:0] complete_ROBNumber,
    output logic                 retire_valid,
    output logic [PREG_W-1:0]    retire_PRegAddrDst,
    output logic [PREG_W-1:0]    retire_OldPRegAddrDst,
    output logic                 retire_free_valid,
    output logic                 rob_empty,
    output logic                 rob_full
);
    import reorder_buffer_pkg::*;

    localparam logic [ROB_IDX_W:0] FULL_COUNT = (ROB_IDX_W+1)'(ROB_DEPTH);

    rob_idx               head_reg;
    rob_idx               tail_reg;
    logic [ROB_IDX_W:0]   count_reg;
    rob_row_struct        rows [ROB_DEPTH];
    rob_row_struct        head_row;
    logic                 dispatch_fire;
    logic                 retire_fire;

    assign rob_full           = (count_reg == FULL_COUNT);
    assign rob_empty          = (count_reg == '0);
    assign dispatch_ready     = !rob_full;
    assign dispatch_ROBNumber = tail_reg;
    assign dispatch_fire      = dispatch_valid && dispatch_ready;

    assign head_row              = rows[head_reg];
    assign retire_valid          = head_row.valid && head_row.complete;
    assign retire_fire           = retire_valid;
    assign retire_PRegAddrDst    = head_row.PRegAddrDst;
    assign retire_OldPRegAddrDst = head_row.OldPRegAddrDst;
    assign retire_free_valid     = retire_valid && head_row.RegWrite;

    // Dispatch only targets an empty row, so it never collides with a retire of the
    // same row; a retire takes precedence over a late completion of its own row.
    genvar gi;
    generate
        for (gi = 0; gi < ROB_DEPTH; gi++) begin : g_row
            localparam rob_idx ROW_IDX = rob_idx'(gi);
            rob_row_struct row_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    row_reg.valid    <= 1'b0;
                    row_reg.complete <= 1'b0;
                end else if (dispatch_fire && tail_reg == ROW_IDX) begin
                    row_reg <= '{valid:          1'b1,
                                 complete:       1'b0,
                                 PRegAddrDst:    dispatch_PRegAddrDst,
                                 OldPRegAddrDst: dispatch_OldPRegAddrDst,
                                 RegWrite:       dispatch_RegWrite};
                end else if (retire_fire && head_reg == ROW_IDX) begin
                    row_reg.valid    <= 1'b0;
                    row_reg.complete <= 1'b0;
                end else if (complete_ready && complete_ROBNumber == ROW_IDX && row_reg.valid) begin
                    row_reg.complete <= 1'b1;
                end
            end

            assign rows[gi] = row_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (dispatch_fire) begin
                tail_reg <= tail_reg + rob_idx'(1);
            end
            if (retire_fire) begin
                head_reg <= head_reg + rob_idx'(1);
            end
            case ({dispatch_fire, retire_fire})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic,
// compared each cycle against a queue-based program-order model.
module tb_reorder_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       dispatch_valid;
    logic [6:0] dispatch_PRegAddrDst;
    logic [6:0] dispatch_OldPRegAddrDst;
    logic       dispatch_RegWrite;
    logic       dispatch_ready;
    logic [3:0] dispatch_ROBNumber;
    logic       complete_ready;
    logic [3:0] complete_ROBNumber;
    logic       retire_valid;
    logic [6:0] retire_PRegAddrDst;
    logic [6:0] retire_OldPRegAddrDst;
    logic       retire_free_valid;
    logic       rob_empty;
    logic       rob_full;

    reorder_buffer dut (
        .clk                    (clk),
        .reset                  (reset),
        .dispatch_valid         (dispatch_valid),
        .dispatch_PRegAddrDst   (dispatch_PRegAddrDst),
        .dispatch_OldPRegAddrDst(dispatch_OldPRegAddrDst),
        .dispatch_RegWrite      (dispatch_RegWrite),
        .dispatch_ready         (dispatch_ready),
        .dispatch_ROBNumber     (dispatch_ROBNumber),
        .complete_ready         (complete_ready),
        .complete_ROBNumber     (complete_ROBNumber),
        .retire_valid           (retire_valid),
        .retire_PRegAddrDst     (retire_PRegAddrDst),
        .retire_OldPRegAddrDst  (retire_OldPRegAddrDst),
        .retire_free_valid      (retire_free_valid),
        .rob_empty              (rob_empty),
        .rob_full               (rob_full)
    );

    always #5 clk = ~clk;

    int vectors_applied = 0;
    int miscompares     = 0;

    // Model: program-order queue of in-flight ROB numbers plus per-number row data.
    int         m_q[$];
    int         m_tail;
    logic [6:0] m_dst [16];
    logic [6:0] m_old [16];
    bit         m_rw  [16];
    bit         m_val [16];
    bit         m_comp[16];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_tail = 0;
        for (int i = 0; i < 16; i++) begin
            m_val[i]  = 1'b0;
            m_comp[i] = 1'b0;
        end
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, then advance the model on the edge.
    task automatic step(input bit dv, input logic [6:0] dst, input logic [6:0] old,
                        input bit rw, input bit cv, input logic [3:0] cn);
        bit exp_ret;
        bit disp;
        int h;
        dispatch_valid          = dv;
        dispatch_PRegAddrDst    = dst;
        dispatch_OldPRegAddrDst = old;
        dispatch_RegWrite       = rw;
        complete_ready          = cv;
        complete_ROBNumber      = cn;
        #1;
        exp_ret = (m_q.size() > 0) && m_comp[m_q[0]];
        disp    = dv && (m_q.size() < 16);
        check_val("dispatch_ready", 32'(dispatch_ready), 32'(m_q.size() < 16));
        check_val("dispatch_ROBNumber", 32'(dispatch_ROBNumber), 32'(m_tail));
        check_val("rob_empty", 32'(rob_empty), 32'(m_q.size() == 0));
        check_val("rob_full", 32'(rob_full), 32'(m_q.size() == 16));
        check_val("retire_valid", 32'(retire_valid), 32'(exp_ret));
        check_val("retire_free_valid", 32'(retire_free_valid), 32'(exp_ret && m_rw[m_q[0]]));
        if (exp_ret) begin
            check_val("retire_PRegAddrDst", 32'(retire_PRegAddrDst), 32'(m_dst[m_q[0]]));
            check_val("retire_OldPRegAddrDst", 32'(retire_OldPRegAddrDst), 32'(m_old[m_q[0]]));
        end
        @(posedge clk);
        if (cv && m_val[cn]) m_comp[cn] = 1'b1;
        if (exp_ret) begin
            h = m_q.pop_front();
            m_val[h]  = 1'b0;
            m_comp[h] = 1'b0;
        end
        if (disp) begin
            m_q.push_back(m_tail);
            m_val[m_tail]  = 1'b1;
            m_comp[m_tail] = 1'b0;
            m_dst[m_tail]  = dst;
            m_old[m_tail]  = old;
            m_rw[m_tail]   = rw;
            m_tail = (m_tail + 1) % 16;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        dispatch_valid = 1'b1;
        complete_ready = 1'b1;
        complete_ROBNumber = (m_q.size() > 0) ? 4'(m_q[0]) : 4'd0;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        reset          = 1'b0;
        dispatch_valid = 1'b0;
        complete_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic disp(input logic [6:0] dst, input logic [6:0] old, input bit rw);
        step(1'b1, dst, old, rw, 1'b0, 4'd0);
    endtask

    task automatic comp(input logic [3:0] cn);
        step(1'b0, 7'd0, 7'd0, 1'b0, 1'b1, cn);
    endtask

    initial begin
        int pick;
        dispatch_valid = 1'b0; dispatch_PRegAddrDst = '0; dispatch_OldPRegAddrDst = '0;
        dispatch_RegWrite = 1'b0; complete_ready = 1'b0; complete_ROBNumber = '0;
        model_clear();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single dispatch, complete, retire
        disp(7'd40, 7'd5, 1'b1);
        comp(4'd0);
        idle(2);

        // Fill to 16, attempt a 17th, then retire head while dispatch is held
        do_reset();
        for (int i = 0; i < 16; i++) disp(7'(i + 20), 7'(i + 60), 1'b1);
        disp(7'd99, 7'd98, 1'b1);
        comp(4'd0);
        disp(7'd11, 7'd12, 1'b1);
        disp(7'd13, 7'd14, 1'b1);

        // Out-of-order completion: 2, 1, then 0
        do_reset();
        for (int i = 0; i < 3; i++) disp(7'(i + 1), 7'(i + 30), 1'b1);
        comp(4'd2);
        comp(4'd1);
        comp(4'd0);
        idle(4);

        // Wrap: move pointers to 14, then dispatch four across the boundary
        do_reset();
        for (int i = 0; i < 14; i++) disp(7'(i), 7'(i + 50), 1'b1);
        for (int i = 0; i < 14; i++) comp(4'(i));
        idle(3);
        for (int i = 0; i < 4; i++) disp(7'(i + 100), 7'(i + 80), 1'(i != 2));
        comp(4'd1); comp(4'd0); comp(4'd15); comp(4'd14);
        idle(5);

        // Completion to an invalid row, store row retirement
        do_reset();
        disp(7'd3, 7'd4, 1'b0);
        comp(4'd9);
        idle(1);
        comp(4'd0);
        idle(2);

        // Reset with five rows in flight, two complete
        for (int i = 0; i < 5; i++) disp(7'(i + 70), 7'(i + 90), 1'b1);
        comp(4'd3); comp(4'd4);
        do_reset();
        idle(2);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                if (m_q.size() > 0 && $urandom_range(0, 99) < 80)
                    pick = m_q[$urandom_range(0, m_q.size() - 1)];
                else
                    pick = $urandom_range(0, 15);
                step(1'($urandom_range(0, 99) < 60), 7'($urandom), 7'($urandom),
                     1'($urandom_range(0, 99) < 75), 1'($urandom_range(0, 99) < 70), 4'(pick));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer for the out-of-order core.
- It is the consumer end of the complete-stage interface: functional units drive completion, identified by ROBNumber, and this block accepts it.
- Allocates one row per renamed instruction at dispatch and returns the ROBNumber that the reservation station carries.
- Marks rows complete when the complete stage reports them, retires from the head strictly in program order, and releases OldPRegAddrDst to the free list.

Parameters:
- ROB_DEPTH, 16, number of rows; must equal 2**ROB_IDX_W.
- ROB_IDX_W, 4, ROBNumber width; matches the 4-bit ROBNumber in rs_row_struct and complete_stage_struct.
- PREG_W, 7, physical register address width (p_reg).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- dispatch_valid  in  1  rename stage presents an instruction.
- dispatch_PRegAddrDst  in  PREG_W  new destination physical register.
- dispatch_OldPRegAddrDst  in  PREG_W  previous mapping, freed at retire.
- dispatch_RegWrite  in  1  instruction writes a register.
- dispatch_ready  out  1  ROB not full; a dispatch is accepted when valid && ready.
- dispatch_ROBNumber  out  ROB_IDX_W  tail index assigned to the accepted dispatch.
- complete_ready  in  1  complete stage reports a finished instruction.
- complete_ROBNumber  in  ROB_IDX_W  row to mark complete.
- retire_valid  out  1  head row retires this cycle.
- retire_PRegAddrDst  out  PREG_W  head PRegAddrDst (newly architectural).
- retire_OldPRegAddrDst  out  PREG_W  head OldPRegAddrDst.
- retire_free_valid  out  1  retire_valid && head RegWrite; push OldPRegAddrDst to the free list.
- rob_empty  out  1  count == 0.
- rob_full  out  1  count == ROB_DEPTH.

Behaviour:
- State: ROB_DEPTH rows of rob_row_struct plus a RegWrite bit each. Also head and tail pointers (ROB_IDX_W bits, natural wrap) and count (ROB_IDX_W+1 bits).
- Reset (synchronous): all valid/complete bits = 0, head = tail = 0, count = 0. Outputs after reset: dispatch_ready = 1, dispatch_ROBNumber = 0, retire_valid = 0, retire_free_valid = 0, rob_empty = 1, rob_full = 0. Reset asserted mid-operation discards all rows the same edge; no retire fires on that edge.
- dispatch_ready = !rob_full, computed from registered count only. A retire in the same cycle does not open a slot until the next cycle.
- dispatch_ROBNumber = tail, combinational.
- Dispatch accepted: at the edge, row[tail] gets valid = 1, complete = 0, and the dst, old dst and RegWrite fields. Tail then increments and wraps 15 -> 0.
- Completion: at the edge, if row[complete_ROBNumber].valid, set complete = 1. A completion to an invalid row is ignored with no state change. Repeated completion of the same row is idempotent.
- retire_valid = row[head].valid && row[head].complete, combinational from registered state. Zero-latency retire: the row is freed at the same edge (valid = 0, complete = 0, head + 1, wraps). Maximum one retire per cycle.
- Completion latency to retire: completion registered at edge N, so retire_valid is high in cycle N+1 at earliest.
- retire_* data outputs show the head row even when retire_valid = 0; they are don't-care in that case.
- Count update: +1 on dispatch, -1 on retire, unchanged when both happen.
- Out-of-order completion of non-head rows sets complete only; retirement waits for the head.
- Store rows (RegWrite = 0) retire normally with retire_free_valid = 0.
- No flush or mispredict recovery in this version.

Decomposition:
- Shared Types package gains: ROB_DEPTH and ROB_IDX_W localparams, typedef rob_idx (logic [ROB_IDX_W-1:0]), and a RegWrite field in rob_row_struct instead of a side array.
- No sub-module. Pointer and count logic is small and stays inline.

Test Plan:
- Reset, then dispatch 1 row (dst 7'd40, old 7'd5, RegWrite 1) -> dispatch_ROBNumber = 0. Then complete_ROBNumber = 0 -> next cycle retire_valid = 1, retire_free_valid = 1, retire_OldPRegAddrDst = 5, then rob_empty = 1.
- Dispatch 16 without completion -> rob_full = 1, dispatch_ready = 0. A 17th dispatch_valid is not accepted; tail stays 0 and count stays 16.
- Dispatch rows 0-2, complete 2 then 1 -> no retire. Complete 0 -> retire_valid high for 3 consecutive cycles in order 0, 1, 2.
- With rob_full, complete head and hold dispatch_valid -> retire and no dispatch on the same edge. Dispatch accepted next cycle into index 0.
- Wrap: advance head/tail to 14, dispatch 4 -> ROBNumbers 14, 15, 0, 1. Completing all -> in-order retire across the wrap.
- complete_ROBNumber = 9 with row 9 invalid -> no state change. A RegWrite = 0 row retires with retire_valid = 1, retire_free_valid = 0.
- Assert reset with 5 valid rows, 2 complete -> next cycle rob_empty = 1, retire_valid = 0.
